// File: rtl/rv32_uart_pkg.sv
// Shared types and constants for the RV32 MMIO UART transmitter.
// FSM state encoding, register offsets and register bit positions.
package rv32_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic [1:0] RegTxData = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegBaud   = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    localparam int unsigned StatusFullBit  = 0;
    localparam int unsigned StatusEmptyBit = 1;
    localparam int unsigned StatusBusyBit  = 2;
    localparam int unsigned StatusOvfBit   = 3;

    localparam int unsigned CtrlIrqEnBit     = 0;
    localparam int unsigned CtrlParityOddBit = 1;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and async active-high reset.
// A push while full is accepted only when a pop happens in the same cycle.
module rv32_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [Aw:0]      count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [Aw:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (Aw+1)'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divider and TX-done interrupt.
// Define RV32_UART_PARITY_EN to add a parity bit (CTRL bit1 selects odd parity).
module rv32_mmio_uart_tx
    import rv32_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  memory_write_enable_i,
    input  logic [31:0] memory_data_address_i,
    input  logic [31:0] memory_write_data_i,
    output logic [31:0] read_data_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned Cw = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]  offset;
    logic        wr, push, pop;
    logic [7:0]  fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [Cw-1:0] fifo_count;
    logic [7:0]  count_byte;
    logic [31:0] rdata;
    logic        unused_bits;

    logic [15:0] baud_q;
    logic        irq_en_q, ovf_q, irq_q, tx_q;
    logic        tx_d, load, bit_end;

    uart_state_e state_q, state_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

`ifdef RV32_UART_PARITY_EN
    logic parity_odd_q, par_q, par_d;
`endif

    assign unused_bits = ^{memory_data_address_i[1:0], memory_write_data_i[31:16]};

    assign sel_o  = (memory_data_address_i[31:4] == BASE_ADDR[31:4]);
    assign offset = memory_data_address_i[3:2];
    assign wr     = sel_o & (|memory_write_enable_i);
    assign push   = wr & (offset == RegTxData) & memory_write_enable_i[0];
    assign count_byte = 8'(fifo_count);

    rv32_sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (memory_write_data_i[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rdata = '0;
        unique case (offset)
            RegStatus: begin
                rdata[StatusFullBit]  = fifo_full;
                rdata[StatusEmptyBit] = fifo_empty;
                rdata[StatusBusyBit]  = (state_q != StIdle);
                rdata[StatusOvfBit]   = ovf_q;
                rdata[15:8]           = count_byte;
            end
            RegBaud: rdata[15:0] = baud_q;
            RegCtrl: begin
                rdata[CtrlIrqEnBit] = irq_en_q;
`ifdef RV32_UART_PARITY_EN
                rdata[CtrlParityOddBit] = parity_odd_q;
`endif
            end
            default: rdata = '0;
        endcase
    end

    assign read_data_o = sel_o ? rdata : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_q   <= DEFAULT_DIV;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef RV32_UART_PARITY_EN
            parity_odd_q <= 1'b0;
`endif
        end else begin
            // A push into a full FIFO is only lost when nothing drains that cycle.
            if (push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end else if (wr && offset == RegStatus && memory_write_enable_i[0]
                         && memory_write_data_i[StatusOvfBit]) begin
                ovf_q <= 1'b0;
            end
            if (wr && offset == RegBaud) begin
                if (memory_write_enable_i[0]) baud_q[7:0]  <= memory_write_data_i[7:0];
                if (memory_write_enable_i[1]) baud_q[15:8] <= memory_write_data_i[15:8];
            end
            if (wr && offset == RegCtrl && memory_write_enable_i[0]) begin
                irq_en_q <= memory_write_data_i[CtrlIrqEnBit];
`ifdef RV32_UART_PARITY_EN
                parity_odd_q <= memory_write_data_i[CtrlParityOddBit];
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef RV32_UART_PARITY_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        tx_d    = 1'b1;
        bit_end = (cnt_q == div_q);
        if (state_q != StIdle) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end
        unique case (state_q)
            StIdle: load = ~fifo_empty;
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RV32_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef RV32_UART_PARITY_EN
            StParity: begin
                tx_d = par_q;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    load    = ~fifo_empty;
                end
            end
            default: state_d = StIdle;
        endcase
        // Frame start: the divider is sampled here so mid-frame BAUD writes wait a frame.
        if (load) begin
            shift_d = fifo_rdata;
            div_d   = baud_q;
            cnt_d   = 16'd0;
            state_d = StStart;
`ifdef RV32_UART_PARITY_EN
            par_d   = (^fifo_rdata) ^ parity_odd_q;
`endif
        end
    end

    assign pop = load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
`ifdef RV32_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_en_q & fifo_empty & (state_q == StIdle);
`ifdef RV32_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// Directed self-checking bench for rv32_mmio_uart_tx.
// Define RV32_UART_PARITY_EN to also exercise the parity frame.
module tb_rv32_mmio_uart_tx;

    localparam logic [31:0] Base = 32'h1000_0000;
    localparam logic [31:0] ATx  = Base + 32'h0;
    localparam logic [31:0] ASt  = Base + 32'h4;
    localparam logic [31:0] ABd  = Base + 32'h8;
    localparam logic [31:0] ACt  = Base + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata;
    logic        sel, tx, irq;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] r;

    rv32_mmio_uart_tx dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .memory_write_enable_i (we),
        .memory_data_address_i (addr),
        .memory_write_data_i   (wdata),
        .read_data_o           (rdata),
        .sel_o                 (sel),
        .tx_o                  (tx),
        .irq_o                 (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = be;
        @(posedge clk);
        #1;
        we   = 4'b0;
        addr = ASt;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        we   = 4'b0;
        #1;
        d = rdata;
    endtask

    // bits[] is the frame LSB-first (start bit at index 0), cpb clocks per bit.
    task automatic sample_frame(input string tag, input logic [31:0] bits, input int nbits,
                                input int cpb);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("%s_bit%0d_clk%0d", tag, b, c), {31'b0, tx}, {31'b0, bits[b]});
            end
        end
    endtask

    initial begin
        logic [19:0] b2b;
        rst = 1'b1; we = 4'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rd(ASt, r); check("rst_status", r, 32'h0000_0002);
        check("rst_sel", {31'b0, sel}, 32'd1);
        rd(ABd, r); check("rst_baud", r, 32'd867);
        rd(ATx, r); check("txdata_reads_zero", r, 32'h0);

        // Decode and byte enables
        @(negedge clk);
        addr = Base + 32'h10; wdata = 32'h41; we = 4'b0001;
        #1;
        check("outside_sel", {31'b0, sel}, 32'd0);
        check("outside_rdata", rdata, 32'h0);
        @(posedge clk); #1; we = 4'b0;
        rd(ASt, r); check("outside_no_push", r, 32'h0000_0002);
        wr(ATx, 32'h41, 4'b0010);
        rd(ASt, r); check("we1_no_push", r, 32'h0000_0002);
        @(posedge clk); #1;
        check("no_frame_tx", {31'b0, tx}, 32'd1);
        wr(ABd, 32'h0000_AB12, 4'b0001);
        rd(ABd, r); check("baud_low_byte", r, 32'h0000_0312);
        rd(ABd + 32'h3, r); check("addr_lsb_ignored", r, 32'h0000_0312);
        wr(ACt, 32'h3, 4'b0001);
        rd(ACt, r);
`ifdef RV32_UART_PARITY_EN
        check("ctrl_rw", r, 32'h3);
`else
        check("ctrl_rw", r, 32'h1);
`endif
        wr(ACt, 32'h0, 4'b0001);

        // Single frame 0x55, div=3
        wr(ABd, 32'd3, 4'b0011);
        wr(ATx, 32'h55, 4'b0001);
        @(posedge clk); #1;
        check("latency_high", {31'b0, tx}, 32'd1);
        sample_frame("f55", 32'b1_01010101_0, 10, 4);
        @(posedge clk); #1;
        check("f55_idle", {31'b0, tx}, 32'd1);
        check("f55_irq_disabled", {31'b0, irq}, 32'd0);
        rd(ASt, r); check("f55_status_idle", r, 32'h0000_0002);

        // Back-to-back 0xA5, 0x3C at div=0 with irq enabled
        wr(ABd, 32'd0, 4'b0011);
        wr(ACt, 32'h1, 4'b0001);
        @(posedge clk); #1;
        check("irq_idle_en", {31'b0, irq}, 32'd1);
        b2b = {10'b1_00111100_0, 10'b1_10100101_0};
        wr(ATx, 32'hA5, 4'b0001);
        wr(ATx, 32'h3C, 4'b0001);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_bit%0d", k), {31'b0, tx}, {31'b0, b2b[k]});
            check($sformatf("b2b_irq%0d", k), {31'b0, irq}, 32'd0);
            if (k < 19) check($sformatf("b2b_busy%0d", k), {31'b0, rdata[2]}, 32'd1);
        end
        @(posedge clk); #1;
        check("b2b_irq_done", {31'b0, irq}, 32'd1);
        check("b2b_tx_idle", {31'b0, tx}, 32'd1);
        rd(ASt, r); check("b2b_status", r, 32'h0000_0002);
        wr(ACt, 32'h0, 4'b0001);

`ifdef RV32_UART_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit is 1
        wr(ATx, 32'h07, 4'b0001);
        @(posedge clk); #1;
        check("par_latency", {31'b0, tx}, 32'd1);
        sample_frame("par07", 32'b1_1_00000111_0, 11, 1);
        @(posedge clk); #1;
        check("par_idle", {31'b0, tx}, 32'd1);
`endif

        // Overflow: 10 pushes at div=1000, 1 popped, 8 held, last dropped
        wr(ABd, 32'd1000, 4'b0011);
        for (int i = 0; i < 10; i++) wr(ATx, i, 4'b0001);
        rd(ASt, r); check("ovf_status", r, 32'h0000_080D);
        wr(ASt, 32'h8, 4'b0001);
        rd(ASt, r); check("ovf_w1c", r, 32'h0000_0805);
        repeat (1200) @(posedge clk);
        #1;
        check("mid_frame_data0", {31'b0, tx}, 32'd0);

        // Reset mid-frame
        @(negedge clk);
        rst = 1'b1; addr = ASt;
        #1;
        check("midrst_tx", {31'b0, tx}, 32'd1);
        check("midrst_status", rdata, 32'h0000_0002);
        addr = ABd;
        #1;
        check("midrst_baud", rdata, 32'd867);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_tx", {31'b0, tx}, 32'd1);
        rd(ASt, r); check("postrst_status", r, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
